// File: rtl/sync_edge_bank.sv
// Multi-channel input synchronizer with per-channel debounce,
// programmable edge detection and sticky event flags.
module sync_edge_bank #(
  parameter int NCH         = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   asynch_sig_in,
  input  logic [1:0]       mode,
  input  logic [DEB_W-1:0] deb_cnt,
  input  logic [NCH-1:0]   evt_clr,
  output logic [NCH-1:0]   lvl,
  output logic [NCH-1:0]   edge_pulse,
  output logic [NCH-1:0]   evt_flag
);

  logic [NCH-1:0]   sync_q [SYNC_STAGES];
  logic [DEB_W-1:0] cnt_q  [NCH];
  logic [DEB_W-1:0] cnt_n  [NCH];
  logic [NCH-1:0]   s;
  logic [NCH-1:0]   lvl_n;
  logic [NCH-1:0]   chg;
  logic [NCH-1:0]   pulse_n;
  logic             rise_en;
  logic             fall_en;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    rise_en = 1'b0;
    fall_en = 1'b0;
    unique case (mode)
      2'b00:   rise_en = 1'b1;
      2'b01:   fall_en = 1'b1;
      2'b10: begin
        rise_en = 1'b1;
        fall_en = 1'b1;
      end
      default: ;
    endcase
  end

  // Counter only runs while s disagrees with lvl; the >= compare
  // caps it at deb_cnt and honours a lowered threshold at once.
  always_comb begin
    lvl_n   = lvl;
    chg     = '0;
    pulse_n = '0;
    for (int i = 0; i < NCH; i++) begin
      cnt_n[i] = '0;
      if (s[i] != lvl[i]) begin
        if (cnt_q[i] >= deb_cnt) begin
          lvl_n[i] = s[i];
          chg[i]   = 1'b1;
        end else begin
          cnt_n[i] = cnt_q[i] + 1'b1;
        end
      end
      pulse_n[i] = chg[i] &
                   (s[i] ? rise_en : fall_en);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++)
        sync_q[k] <= '0;
      for (int i = 0; i < NCH; i++)
        cnt_q[i] <= '0;
      lvl        <= '0;
      edge_pulse <= '0;
      evt_flag   <= '0;
    end else begin
      sync_q[0] <= asynch_sig_in;
      for (int k = 1; k < SYNC_STAGES; k++)
        sync_q[k] <= sync_q[k-1];
      for (int i = 0; i < NCH; i++)
        cnt_q[i] <= cnt_n[i];
      lvl        <= lvl_n;
      edge_pulse <= pulse_n;
      // Set dominates a coincident clear.
      evt_flag   <= pulse_n | (evt_flag & ~evt_clr);
    end
  end

endmodule

// File: tb/tb_sync_edge_bank.sv
// Directed bench for sync_edge_bank (NCH=4, SYNC_STAGES=2, DEB_W=4).
// Inputs change 1ns after a rising edge; outputs sampled 1ns after.
module tb_sync_edge_bank;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] asynch_sig_in;
  logic [1:0] mode;
  logic [3:0] deb_cnt;
  logic [3:0] evt_clr;
  logic [3:0] lvl;
  logic [3:0] edge_pulse;
  logic [3:0] evt_flag;

  int checks = 0;
  int errors = 0;

  sync_edge_bank #(
    .NCH(4),
    .SYNC_STAGES(2),
    .DEB_W(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .asynch_sig_in(asynch_sig_in),
    .mode(mode),
    .deb_cnt(deb_cnt),
    .evt_clr(evt_clr),
    .lvl(lvl),
    .edge_pulse(edge_pulse),
    .evt_flag(evt_flag)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag,
                     input logic [3:0] obs,
                     input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag,
                      input logic [3:0] l,
                      input logic [3:0] p,
                      input logic [3:0] f);
    chk({tag, ".lvl"}, lvl, l);
    chk({tag, ".pulse"}, edge_pulse, p);
    chk({tag, ".flag"}, evt_flag, f);
  endtask

  initial begin
    rst_n = 1'b0;
    asynch_sig_in = '0;
    mode = 2'b00;
    deb_cnt = '0;
    evt_clr = '0;
    #3;
    chk3("rst_init", 4'h0, 4'h0, 4'h0);
    tick(2);
    rst_n = 1'b1;

    // ch0 rise, no debounce
    asynch_sig_in = 4'b0001;
    tick(2);
    chk3("r28_k1", 4'b0000, 4'b0000, 4'b0000);
    tick();
    chk3("r28_k2", 4'b0001, 4'b0001, 4'b0001);
    tick();
    chk3("r28_k3", 4'b0001, 4'b0000, 4'b0001);

    // ch1 glitch of 3 cycles with deb_cnt=3
    deb_cnt = 4'd3;
    asynch_sig_in = 4'b0011;
    tick(3);
    asynch_sig_in = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("r29_glitch_pulse", edge_pulse, 4'b0000);
    end
    chk("r29_glitch_lvl", lvl, 4'b0001);

    // ch1 held high
    asynch_sig_in = 4'b0011;
    tick(5);
    chk3("r29_k4", 4'b0001, 4'b0000, 4'b0001);
    tick();
    chk3("r29_k5", 4'b0011, 4'b0010, 4'b0011);
    tick();
    chk("r29_k6_pulse", edge_pulse, 4'b0000);

    // mode both on ch2
    deb_cnt = 4'd0;
    mode = 2'b10;
    asynch_sig_in = 4'b0111;
    tick(3);
    chk3("r30_both_rise", 4'b0111, 4'b0100, 4'b0111);
    tick();
    chk("r30_both_rise_end", edge_pulse, 4'b0000);
    asynch_sig_in = 4'b0011;
    tick(3);
    chk3("r30_both_fall", 4'b0011, 4'b0100, 4'b0111);
    tick();
    chk("r30_both_fall_end", edge_pulse, 4'b0000);
    evt_clr = 4'b1111;
    tick();
    chk("r30_clr", evt_flag, 4'b0000);
    evt_clr = 4'b0000;

    // mode fall
    mode = 2'b01;
    asynch_sig_in = 4'b0111;
    tick(3);
    chk3("r30_fall_rise", 4'b0111, 4'b0000, 4'b0000);
    tick();
    asynch_sig_in = 4'b0011;
    tick(3);
    chk3("r30_fall_fall", 4'b0011, 4'b0100, 4'b0100);
    tick();
    chk("r30_fall_end", edge_pulse, 4'b0000);

    // mode disabled: lvl tracks, nothing flagged
    mode = 2'b11;
    asynch_sig_in = 4'b0111;
    tick(3);
    chk3("r30_off_rise", 4'b0111, 4'b0000, 4'b0100);
    tick();
    asynch_sig_in = 4'b0011;
    tick(3);
    chk3("r30_off_fall", 4'b0011, 4'b0000, 4'b0100);

    // clear vs set priority on ch3
    mode = 2'b00;
    evt_clr = 4'b1111;
    tick();
    chk("r31_preclr", evt_flag, 4'b0000);
    evt_clr = 4'b0000;
    asynch_sig_in = 4'b1011;
    tick(2);
    evt_clr = 4'b1000;
    tick();
    chk3("r31_set_wins", 4'b1011, 4'b1000, 4'b1000);
    tick();
    chk3("r31_clr", 4'b1011, 4'b0000, 4'b0000);
    evt_clr = 4'b0000;

    // reset mid-debounce
    asynch_sig_in = 4'b1000;
    tick(4);
    chk("r32_pre_lvl", lvl, 4'b1000);
    deb_cnt = 4'd3;
    asynch_sig_in = 4'b1001;
    tick(3);
    chk("r32_mid_lvl", lvl, 4'b1000);
    #2;
    rst_n = 1'b0;
    #1;
    chk3("r27_async_rst", 4'b0000, 4'b0000, 4'b0000);
    tick();
    chk3("r32_held", 4'b0000, 4'b0000, 4'b0000);
    rst_n = 1'b1;
    tick(5);
    chk3("r32_k4", 4'b0000, 4'b0000, 4'b0000);
    tick();
    chk3("r32_k5", 4'b1001, 4'b1001, 4'b1001);
    tick();
    chk3("r32_k6", 4'b1001, 4'b0000, 4'b1001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
